// File: rtl/icache_fill_ctrl.sv
// Instruction-cache controller: hits, WORDS_PER_LINE-beat line fills, flush walker, hit/miss stats.
// Latency: hit -> resp_valid one cycle after acceptance; miss -> resp_valid one cycle after last beat.
// Backpressure: req_ready only in IDLE; mem_ready beats may have arbitrary gaps, mem_rd held throughout.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid, hit        fetch request and its tag-compare result
//   req_ready             request accepted when req_valid & req_ready
//   cache_rd, resp_valid  data-array read strobe / fetch data valid (identical)
//   stall                 pipeline stall during FLUSH and FILL
//   mem_rd, mem_ready     memory line read (held for the fill) / one beat valid
//   cache_wr, w_sel       data-array write strobe and word index of the current beat
//   flush_req             one-cycle pulse requesting full invalidation
//   cache_reset, flush_idx invalidate the line at flush_idx
//   clr_stats             synchronous clear of hit_cnt / miss_cnt (saturating counters)
module icache_fill_ctrl #(
  parameter int WORDS_PER_LINE = 2,
  parameter int NUM_LINES      = 16,
  parameter int CNT_W          = 16,
  localparam int WS_W          = $clog2(WORDS_PER_LINE),
  localparam int FI_W          = $clog2(NUM_LINES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             hit,
  output logic             req_ready,
  output logic             cache_rd,
  output logic             resp_valid,
  output logic             stall,
  output logic             mem_rd,
  input  logic             mem_ready,
  output logic             cache_wr,
  output logic [WS_W-1:0]  w_sel,
  input  logic             flush_req,
  output logic             cache_reset,
  output logic [FI_W-1:0]  flush_idx,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    IDLE  = 2'd1,
    RD    = 2'd2,
    FILL  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [WS_W-1:0] beat, beat_nxt;
  logic [FI_W-1:0] fidx, fidx_nxt;
  logic            pend, pend_nxt;
  logic            acc_hit, acc_miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FLUSH;
      beat  <= '0;
      fidx  <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      fidx  <= fidx_nxt;
      pend  <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    fidx_nxt  = fidx;
    pend_nxt  = pend;
    acc_hit   = 1'b0;
    acc_miss  = 1'b0;
    case (state)
      FLUSH: begin
        // flush_req here is deliberately ignored: a walk is already in progress.
        if (fidx == FI_W'(NUM_LINES - 1)) begin
          fidx_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          fidx_nxt = fidx + FI_W'(1);
        end
      end
      IDLE: begin
        // A flush wins over a simultaneous request, which is then not accepted.
        if (flush_req) begin
          state_nxt = FLUSH;
          fidx_nxt  = '0;
        end else if (req_valid) begin
          if (hit) begin
            acc_hit   = 1'b1;
            state_nxt = RD;
          end else begin
            acc_miss  = 1'b1;
            beat_nxt  = '0;
            state_nxt = FILL;
          end
        end
      end
      RD: begin
        // A flush_req in this very cycle is treated like an already pending one.
        if (pend || flush_req) begin
          pend_nxt  = 1'b0;
          fidx_nxt  = '0;
          state_nxt = FLUSH;
        end else begin
          state_nxt = IDLE;
        end
      end
      FILL: begin
        // Fills are never aborted; a flush is remembered until after the replay read.
        if (flush_req) begin
          pend_nxt = 1'b1;
        end
        if (mem_ready) begin
          if (beat == WS_W'(WORDS_PER_LINE - 1)) begin
            beat_nxt  = '0;
            state_nxt = RD;
          end else begin
            beat_nxt = beat + WS_W'(1);
          end
        end
      end
      default: state_nxt = FLUSH;
    endcase
  end

  // Saturating statistics; clear beats a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (clr_stats) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (acc_hit && (hit_cnt != {CNT_W{1'b1}})) begin
        hit_cnt <= hit_cnt + CNT_W'(1);
      end
      if (acc_miss && (miss_cnt != {CNT_W{1'b1}})) begin
        miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end

  // All outputs decode from state so they drop with the asynchronous reset;
  // cache_wr alone is combinational so the beat is written in its own cycle.
  assign req_ready   = (state == IDLE);
  assign cache_rd    = (state == RD);
  assign resp_valid  = (state == RD);
  assign stall       = (state == FLUSH) || (state == FILL);
  assign mem_rd      = (state == FILL);
  assign cache_wr    = (state == FILL) && mem_ready;
  assign cache_reset = (state == FLUSH);
  assign w_sel       = beat;
  assign flush_idx   = fidx;

endmodule

// File: doc/icache_fill_ctrl.md
# icache_fill_ctrl

Parametrised instruction-cache controller that sequences hits, multi-word line fills from memory and whole-cache invalidation. It sits between the fetch stage, the tag/data arrays and the memory port. It generalises the fixed two-word fill to WORDS_PER_LINE beats. It adds a request/ready handshake, a hardware flush walker, deferred flush requests and saturating hit/miss statistics.

## Interface
- WORDS_PER_LINE, 2, words per cache line; power of two, >= 2
- NUM_LINES, 16, lines invalidated by a flush; power of two, >= 2
- CNT_W, 16, width of each statistics counter
- Derived: WS_W = clog2(WORDS_PER_LINE), FI_W = clog2(NUM_LINES)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  fetch request present
- hit  in  1  tag-compare result for the current request; valid whenever req_valid=1
- req_ready  out  1  request accepted this cycle (req_valid & req_ready)
- cache_rd  out  1  data-array read strobe
- resp_valid  out  1  fetch data valid to the pipeline; equal to cache_rd
- stall  out  1  pipeline stall
- mem_rd  out  1  memory line-read request; held for the whole fill
- mem_ready  in  1  one memory data beat valid this cycle
- cache_wr  out  1  data-array write strobe for the current beat
- w_sel  out  WS_W  word index of the beat being written
- flush_req  in  1  one-cycle pulse requesting full invalidation
- cache_reset  out  1  invalidate the line at flush_idx
- flush_idx  out  FI_W  line being invalidated
- clr_stats  in  1  synchronous clear of both counters
- hit_cnt  out  CNT_W  accepted hits, saturating
- miss_cnt  out  CNT_W  accepted misses, saturating

## Operation
- States: FLUSH, IDLE, RD, FILL.
- FLUSH: cache_reset=1 and stall=1. flush_idx increments by one each cycle from 0. After the cycle with flush_idx=NUM_LINES-1, the state goes to IDLE and flush_idx returns to 0.
- IDLE: req_ready=1 and stall=0.
  - flush_req=1 goes to FLUSH. This has priority over req_valid, and the request is not accepted that cycle.
  - Otherwise, req_valid & hit goes to RD.
  - Otherwise, req_valid & !hit goes to FILL with the beat counter at 0.
- RD: cache_rd=1 and resp_valid=1 for exactly one cycle. Next state is FLUSH if a flush is pending, else IDLE.
- FILL: mem_rd=1, stall=1, and w_sel is the beat counter.
  - cache_wr is decoded combinationally as FILL & mem_ready, so it is asserted in the same cycle as the beat.
  - Each mem_ready increments the beat counter.
  - A mem_ready seen while the counter is WORDS_PER_LINE-1 ends the fill: the counter wraps to 0 and the state goes to RD, which replays the request as a hit.
  - Gaps of any length between beats are legal; mem_rd stays 1 through them.
- Pending flush: a flush_req seen in FILL or RD sets a pending flag. The flag is serviced on exit from RD, and a fill is never aborted by a flush. A flush_req arriving during FLUSH is ignored.
- req_ready=0 in every state except IDLE.
- mem_ready outside FILL is ignored and produces no cache_wr.
- Counters:
  - hit_cnt increments on an accepted hit; miss_cnt increments on an accepted miss.
  - The replay in RD after a fill does not count as a hit.
  - Both counters hold at all-ones.
  - clr_stats zeroes both counters. If clr_stats coincides with an increment, the clear wins.

## Timing
- During rst_n=0 and on its release, outputs are:
  - state FLUSH, cache_reset=1, stall=1, flush_idx=0
  - req_ready=0, cache_rd=0, resp_valid=0, mem_rd=0, w_sel=0
  - cache_wr=0, both counters 0, pending flag cleared
- The first cycle after reset release is flush_idx=0. IDLE is reached NUM_LINES cycles after release.
- Reset asserted mid-fill or mid-flush aborts immediately: mem_rd falls asynchronously. Memory must tolerate an abandoned read.
- Hit latency: request accepted at edge N, resp_valid=1 in cycle N+1, req_ready=1 again in cycle N+2.
- Miss latency: mem_rd=1 from the cycle after acceptance. resp_valid comes one cycle after the last mem_ready. The minimum is WORDS_PER_LINE+1 cycles after acceptance.
- mem_rd falls in the cycle after the final beat.
- All outputs are registered or state-decoded, except cache_wr, which is combinational from mem_ready.

## Test plan
- Reset: release rst_n with NUM_LINES=16. Required response: flush_idx steps 0..15 with cache_reset=1, then IDLE with req_ready=1, all counters 0.
- Hit: req_valid=1, hit=1 in IDLE. Required response: resp_valid=1 exactly one cycle later, hit_cnt=1, mem_rd never asserted.
- Miss, WORDS_PER_LINE=4, mem_ready on 4 non-consecutive cycles. Required response:
  - cache_wr=1 only on those cycles, with w_sel=0,1,2,3.
  - mem_rd continuous.
  - resp_valid one cycle after the 4th beat.
  - miss_cnt=1, hit_cnt=0.
- flush_req pulsed mid-fill. Required response: the fill completes and RD occurs, then a 16-cycle FLUSH, then IDLE. Separately, flush_req and req_valid asserted together in IDLE: FLUSH is taken and the request is not accepted.
- Saturation, CNT_W=4: 17 hits. Required response: hit_cnt=15. Then clr_stats asserted together with a hit: hit_cnt=0.
- rst_n pulsed low after the 2nd beat of a 4-beat fill. Required response: mem_rd=0 immediately, the flush restarts at flush_idx=0, and the fill is not resumed.
